// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmitter arbiter: FSM state encoding and
// the default timeout while waiting for the transmitter to report busy.
package uart_arb_pkg;

    localparam int WAIT_LIMIT_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr upward,
// wrapping from NUM_REQ-1 back to 0.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    always_comb begin
        int  j;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr_i) + i) % NUM_REQ;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART transmitter between NUM_REQ sources.
// Optional packet locking (keep the winner until req_last) with UART_ARB_PACKET_LOCK_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int IDX_W      = 2,
    parameter int WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 err,
    output logic                 arb_busy,
    output logic                 tx_en,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    input  logic                 tx_done
);

    localparam int CNT_W = $clog2(WAIT_LIMIT);

    arb_state_t         state_q;
    logic [IDX_W-1:0]   ptr_q, win_q;
    logic [NUM_REQ-1:0] gnt_q, ack_q;
    logic               err_q, tx_en_q, tx_start_q;
    logic [7:0]         tx_data_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [IDX_W-1:0]   pick_ptr, pick_idx, sel_idx;
    logic [NUM_REQ-1:0] pick_gnt, sel_gnt;
    logic               pick_any, sel_any;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req_i (req),
        .ptr_i (pick_ptr),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

`ifdef UART_ARB_PACKET_LOCK_EN
    logic lock_q;

    // A locked winner that dropped req hands over as if its packet had ended.
    assign pick_ptr = lock_q ? next_idx(win_q) : ptr_q;

    always_comb begin
        sel_any = pick_any;
        sel_idx = pick_idx;
        sel_gnt = pick_gnt;
        if (lock_q && req[win_q]) begin
            sel_any = 1'b1;
            sel_idx = win_q;
            sel_gnt = NUM_REQ'(1) << win_q;
        end
    end
`else
    logic unused_last;

    assign unused_last = ^req_last;
    assign pick_ptr    = ptr_q;
    assign sel_any     = pick_any;
    assign sel_idx     = pick_idx;
    assign sel_gnt     = pick_gnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            tx_en_q    <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            cnt_q      <= '0;
`ifdef UART_ARB_PACKET_LOCK_EN
            lock_q     <= 1'b0;
`endif
        end else begin
            tx_en_q    <= 1'b1;
            tx_start_q <= 1'b0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
`ifdef UART_ARB_PACKET_LOCK_EN
                    if (lock_q) begin
                        lock_q <= 1'b0;
                        if (!req[win_q]) ptr_q <= next_idx(win_q);
                    end
`endif
                    if (sel_any) begin
                        gnt_q      <= sel_gnt;
                        win_q      <= sel_idx;
                        tx_data_q  <= req_data[{sel_idx, 3'b000} +: 8];
                        tx_start_q <= 1'b1;
                        state_q    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (cnt_q == CNT_W'(WAIT_LIMIT - 2)) begin
                        // err becomes visible exactly WAIT_LIMIT cycles after tx_start
                        err_q   <= 1'b1;
                        gnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        ack_q   <= gnt_q;
                        gnt_q   <= '0;
                        state_q <= IDLE;
`ifdef UART_ARB_PACKET_LOCK_EN
                        if (req_last[win_q]) ptr_q  <= next_idx(win_q);
                        else                 lock_q <= 1'b1;
`else
                        ptr_q <= next_idx(win_q);
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign ack      = ack_q;
    assign err      = err_q;
    assign arb_busy = (state_q != IDLE);
    assign tx_en    = tx_en_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: byte sources, a transmitter model and a queue-based
// reference of the expected send order. Honours UART_ARB_PACKET_LOCK_EN when defined.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int LIMIT = 16;
    localparam int FRAME = 10;
    localparam int DEPTH = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   gnt, ack;
    logic           err, arb_busy, tx_en, tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy = 1'b0;
    logic           tx_done = 1'b0;

    uart_tx_arbiter #(.NUM_REQ(N), .IDX_W(2), .WAIT_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .gnt(gnt), .ack(ack), .err(err), .arb_busy(arb_busy), .tx_en(tx_en),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // source storage and control
    logic [7:0] mem   [N][DEPTH];
    bit         lastm [N][DEPTH];
    int         head  [N];
    int         cnt   [N];
    bit         drv_en  = 1'b0;
    bit         busy_en = 1'b1;
    int         req_rise_cyc = 0;

    // observation logs and reference
    logic [7:0] obs_data[$];
    int         obs_src[$], start_cyc[$], ack_src[$], ack_cyc[$], done_cyc[$], err_cyc[$], gnt_rise_cyc[$];
    int         viol = 0;
    logic [7:0] exp_q[$];
    int         exp_src[$];

    logic [N-1:0] prev_gnt = '0;
    logic [N-1:0] prev_req;
    logic [7:0]   held = '0;
    bit           m_active = 1'b0;
    int           m_cnt = 0;

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Observe, then update sources, then step the transmitter model.
    always @(negedge clk) begin
        if (tx_start) begin
            obs_data.push_back(tx_data);
            obs_src.push_back(oh_idx(gnt));
            start_cyc.push_back(cyc);
            held = tx_data;
            if ($countones(gnt) != 1) viol++;
        end
        if (ack != '0) begin
            ack_src.push_back(oh_idx(ack));
            ack_cyc.push_back(cyc);
            if ($countones(ack) != 1) viol++;
        end
        if (err) err_cyc.push_back(cyc);
        if (gnt != '0 && prev_gnt == '0) gnt_rise_cyc.push_back(cyc);
        if (gnt != '0 && $countones(gnt) != 1) viol++;
        if (gnt != '0 && !tx_start && tx_data !== held) viol++;
        prev_gnt = gnt;

        prev_req = req;
        if (drv_en) begin
            for (int i = 0; i < N; i++) begin
                if (ack[i] && head[i] < cnt[i]) head[i]++;
                if (head[i] < cnt[i]) begin
                    req[i] = 1'b1;
                    req_data[8*i +: 8] = mem[i][head[i]];
                    req_last[i] = lastm[i][head[i]];
                end else begin
                    req[i] = 1'b0;
                    req_last[i] = 1'b0;
                end
            end
        end else begin
            req = '0;
            req_last = '0;
        end
        if (prev_req == '0 && req != '0) req_rise_cyc = cyc;

        tx_done = 1'b0;
        if (m_active) begin
            m_cnt++;
            if (m_cnt == FRAME) begin
                tx_done  = 1'b1;
                tx_busy  = 1'b0;
                m_active = 1'b0;
                done_cyc.push_back(cyc);
            end
        end else if (tx_start) begin
            m_active = 1'b1;
            m_cnt    = 0;
            tx_busy  = busy_en;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int src, input logic [7:0] d, input bit last);
        mem[src][cnt[src]]   = d;
        lastm[src][cnt[src]] = last;
        cnt[src]++;
    endtask

    task automatic clear_logs();
        obs_data.delete(); obs_src.delete(); start_cyc.delete(); ack_src.delete();
        ack_cyc.delete(); done_cyc.delete(); err_cyc.delete(); gnt_rise_cyc.delete();
        viol = 0;
    endtask

    task automatic do_reset();
        drv_en = 1'b0;
        for (int t = 0; t < 40 && m_active; t++) tick();
        busy_en = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            cnt[i]  = 0;
        end
        clear_logs();
    endtask

    task automatic wait_acks(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget; t++) begin
            tick();
            if (ack_src.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Reference order: scan sources from a pointer, one byte per turn; with packet
    // locking a source keeps the turn until it sends a byte marked last or runs dry.
    task automatic build_expected();
        int ptr, lock, w, j;
        int rem[N];
        int hd[N];
        ptr  = 0;
        lock = -1;
        exp_q.delete();
        exp_src.delete();
        for (int i = 0; i < N; i++) begin
            rem[i] = cnt[i];
            hd[i]  = 0;
        end
        while (1) begin
            w = -1;
`ifdef UART_ARB_PACKET_LOCK_EN
            if (lock >= 0) begin
                if (rem[lock] > 0) w = lock;
                else ptr = (lock + 1) % N;
                lock = -1;
            end
`endif
            if (w < 0) begin
                for (int k = 0; k < N; k++) begin
                    j = (ptr + k) % N;
                    if (w < 0 && rem[j] > 0) w = j;
                end
            end
            if (w < 0) break;
            exp_q.push_back(mem[w][hd[w]]);
            exp_src.push_back(w);
`ifdef UART_ARB_PACKET_LOCK_EN
            if (lastm[w][hd[w]]) ptr = (w + 1) % N;
            else lock = w;
`else
            ptr = (w + 1) % N;
`endif
            hd[w]++;
            rem[w]--;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if ({gnt, ack, err, arb_busy, tx_start, tx_en, tx_data} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: gnt=%b ack=%b err=%b busy=%b start=%b en=%b data=%h, all required 0",
                     gnt, ack, err, arb_busy, tx_start, tx_en, tx_data);
        end
        rst = 1'b0;
        tick();
        tests++;
        if (tx_en !== 1'b1 || arb_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: tx_en=%b arb_busy=%b, required 1/0", tx_en, arb_busy);
        end
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        load(0, 8'h55, 1'b1);
        drv_en = 1'b1;
        wait_acks(1, 60, ok);
        tick();
        tick();
        tests++;
        if (!ok) begin fails++; $display("FAIL single_timeout: no ack within 60 cycles"); end
        tests++;
        if (gnt_rise_cyc.size() < 1 || gnt_rise_cyc[0] != req_rise_cyc + 1) begin
            fails++;
            $display("FAIL single_gnt_latency: gnt at cycle %0d, required %0d",
                     (gnt_rise_cyc.size() > 0) ? gnt_rise_cyc[0] : -1, req_rise_cyc + 1);
        end
        tests++;
        if (obs_data.size() != 1 || obs_data[0] !== 8'h55 || obs_src[0] != 0) begin
            fails++;
            $display("FAIL single_start: %0d starts, data=%h src=%0d, required 1 start data=55 src=0",
                     obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : 8'hxx,
                     (obs_src.size() > 0) ? obs_src[0] : -1);
        end
        tests++;
        if (ack_src.size() != 1 || ack_src[0] != 0 || done_cyc.size() < 1 || ack_cyc[0] != done_cyc[0] + 1) begin
            fails++;
            $display("FAIL single_ack: %0d acks, src=%0d at cycle %0d, required 1 ack src=0 at cycle %0d",
                     ack_src.size(), (ack_src.size() > 0) ? ack_src[0] : -1,
                     (ack_cyc.size() > 0) ? ack_cyc[0] : -1, (done_cyc.size() > 0) ? done_cyc[0] + 1 : -1);
        end
        tests++;
        if (err_cyc.size() != 0 || gnt !== '0 || viol != 0) begin
            fails++;
            $display("FAIL single_clean: err=%0d gnt=%b protocol_viol=%0d, required 0/0000/0",
                     err_cyc.size(), gnt, viol);
        end
    endtask

    task automatic test_all_four();
        bit ok;
        do_reset();
        for (int i = 0; i < N; i++) load(i, 8'hA0 + 8'(i), 1'b1);
        drv_en = 1'b1;
        wait_acks(4, 100, ok);
        for (int t = 0; t < 14; t++) tick();
        tests++;
        if (!ok || ack_src.size() != 4 || obs_data.size() != 4) begin
            fails++;
            $display("FAIL four_counts: acks=%0d starts=%0d, required 4/4", ack_src.size(), obs_data.size());
        end
        for (int i = 0; i < 4 && i < obs_data.size() && i < ack_src.size(); i++) begin
            tests++;
            if (obs_data[i] !== 8'hA0 + 8'(i) || obs_src[i] != i || ack_src[i] != i) begin
                fails++;
                $display("FAIL four_order[%0d]: data=%h src=%0d ack=%0d, required %h/%0d/%0d",
                         i, obs_data[i], obs_src[i], ack_src[i], 8'hA0 + 8'(i), i, i);
            end
            if (i > 0) begin
                tests++;
                if (start_cyc[i] - start_cyc[i-1] != FRAME + 2) begin
                    fails++;
                    $display("FAIL four_spacing[%0d]: %0d cycles between starts, required %0d",
                             i, start_cyc[i] - start_cyc[i-1], FRAME + 2);
                end
            end
        end
        tests++;
        if (viol != 0 || err_cyc.size() != 0) begin
            fails++;
            $display("FAIL four_protocol: viol=%0d err=%0d, required 0/0", viol, err_cyc.size());
        end
    endtask

    task automatic test_rr_fair();
        bit ok;
        int bad;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            load(0, 8'($urandom_range(0, 255)), 1'b1);
            load(2, 8'($urandom_range(0, 255)), 1'b1);
        end
        drv_en = 1'b1;
        wait_acks(20, 300, ok);
        bad = 0;
        for (int i = 0; i < 20 && i < obs_src.size(); i++)
            if (obs_src[i] != ((i % 2 == 0) ? 0 : 2) || obs_data[i] !== mem[obs_src[i] == 2 ? 2 : 0][i / 2]) bad++;
        tests++;
        if (!ok || obs_src.size() != 20 || bad != 0 || viol != 0) begin
            fails++;
            $display("FAIL rr_fair: ok=%0d starts=%0d misordered=%0d viol=%0d, required 1/20/0/0",
                     ok, obs_src.size(), bad, viol);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [7:0] b;
        do_reset();
        b = 8'($urandom_range(0, 255));
        busy_en = 1'b0;
        load(2, b, 1'b1);
        drv_en = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 60; t++) begin
            tick();
            if (err_cyc.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
        busy_en = 1'b1;
        tests++;
        if (!ok || start_cyc.size() < 1 || err_cyc[0] - start_cyc[0] != LIMIT) begin
            fails++;
            $display("FAIL timeout_err: seen=%0d err %0d cycles after start, required %0d",
                     ok, (ok && start_cyc.size() > 0) ? err_cyc[0] - start_cyc[0] : -1, LIMIT);
        end
        tests++;
        if (ack_src.size() != 0 || gnt !== '0 || arb_busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout_state: acks=%0d gnt=%b arb_busy=%b, required 0/0000/0",
                     ack_src.size(), gnt, arb_busy);
        end
        wait_acks(1, 60, ok);
        tick();
        tick();
        tests++;
        if (!ok || obs_data.size() != 2 || obs_data[1] !== b || ack_src[0] != 2 || err_cyc.size() != 1) begin
            fails++;
            $display("FAIL timeout_retry: ok=%0d starts=%0d acks=%0d errs=%0d, required 1/2/1/1",
                     ok, obs_data.size(), ack_src.size(), err_cyc.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [7:0] b0;
        do_reset();
        load(1, 8'($urandom_range(0, 255)), 1'b1);
        load(2, 8'($urandom_range(0, 255)), 1'b1);
        drv_en = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 60; t++) begin
            tick();
            if (obs_data.size() >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        for (int t = 0; t < 4; t++) tick();
        rst = 1'b1;
        drv_en = 1'b0;
        tick();
        tests++;
        if (!ok || {gnt, ack, err, arb_busy, tx_start, tx_en, tx_data} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: reached=%0d gnt=%b ack=%b err=%b busy=%b en=%b data=%h, required all 0",
                     ok, gnt, ack, err, arb_busy, tx_en, tx_data);
        end
        rst = 1'b0;
        for (int t = 0; t < 14; t++) tick();
        tests++;
        if (ack_src.size() != 1 || err_cyc.size() != 0 || done_cyc.size() != 2) begin
            fails++;
            $display("FAIL midreset_stray_done: acks=%0d errs=%0d dones=%0d, required 1/0/2",
                     ack_src.size(), err_cyc.size(), done_cyc.size());
        end
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            cnt[i]  = 0;
        end
        b0 = 8'($urandom_range(0, 255));
        load(0, b0, 1'b1);
        load(3, 8'($urandom_range(0, 255)), 1'b1);
        drv_en = 1'b1;
        wait_acks(3, 80, ok);
        tests++;
        if (!ok || obs_src.size() < 3 || obs_src[2] != 0 || obs_data[2] !== b0 || ack_src[1] != 0) begin
            fails++;
            $display("FAIL midreset_ptr: ok=%0d first src after reset=%0d, required 0",
                     ok, (obs_src.size() > 2) ? obs_src[2] : -1);
        end
    endtask

    task automatic test_packet_lock();
        bit ok;
        int exp_order[4];
`ifdef UART_ARB_PACKET_LOCK_EN
        exp_order = '{1, 1, 1, 3};
`else
        exp_order = '{1, 3, 1, 1};
`endif
        do_reset();
        load(1, 8'h11, 1'b0);
        load(1, 8'h12, 1'b0);
        load(1, 8'h13, 1'b1);
        load(3, 8'h31, 1'b1);
        drv_en = 1'b1;
        wait_acks(4, 100, ok);
        tests++;
        if (!ok || obs_src.size() != 4) begin
            fails++;
            $display("FAIL lock_count: ok=%0d starts=%0d, required 1/4", ok, obs_src.size());
        end
        for (int i = 0; i < 4 && i < obs_src.size(); i++) begin
            tests++;
            if (obs_src[i] != exp_order[i]) begin
                fails++;
                $display("FAIL lock_order[%0d]: src=%0d, required %0d", i, obs_src[i], exp_order[i]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int total;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            total = 0;
            for (int i = 0; i < N; i++) begin
                int n;
                n = $urandom_range(0, 5);
                for (int k = 0; k < n; k++) load(i, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
                total += n;
            end
            if (total == 0) begin
                load(0, 8'($urandom_range(0, 255)), 1'b1);
                total = 1;
            end
            build_expected();
            drv_en = 1'b1;
            wait_acks(total, total * (FRAME + 2) + 60, ok);
            tests++;
            if (!ok || obs_data.size() != exp_q.size() || ack_src.size() != exp_src.size()) begin
                fails++;
                $display("FAIL random[%0d]_count: starts=%0d acks=%0d, required %0d",
                         r, obs_data.size(), ack_src.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_data.size() && i < ack_src.size(); i++) begin
                tests++;
                if (obs_data[i] !== exp_q[i] || obs_src[i] != exp_src[i] || ack_src[i] != exp_src[i]) begin
                    fails++;
                    $display("FAIL random[%0d]_byte[%0d]: data=%h src=%0d ack=%0d, required %h/%0d",
                             r, i, obs_data[i], obs_src[i], ack_src[i], exp_q[i], exp_src[i]);
                end
            end
            tests++;
            if (viol != 0 || err_cyc.size() != 0) begin
                fails++;
                $display("FAIL random[%0d]_protocol: viol=%0d errs=%0d, required 0/0", r, viol, err_cyc.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_rr_fair();
        test_timeout();
        test_reset_mid();
        test_packet_lock();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", tests);
        $fatal(1, "watchdog");
    end

endmodule
